// File: rtl/braun_pkg.sv
// Shared constants for the Braun array multiplier and the datapath stages that align to it.
// Latency: 1 cycle, or 2 when BRAUN_MULT_PIPE_EN is defined. Backpressure: none.
// Backpressure behaviour: not applicable; this package holds widths and latency only.
package braun_pkg;

   localparam int BRAUN_N_DEF = 8;

   function automatic int braun_prod_w(input int n);
      return 2 * n;
   endfunction

   // Adder row after which the optional pipeline register is placed.
   function automatic int braun_cut_row(input int n);
      return n / 2;
   endfunction

   localparam int BRAUN_P_W_DEF = braun_prod_w(BRAUN_N_DEF);

`ifdef BRAUN_MULT_PIPE_EN
   localparam int BRAUN_LATENCY = 2;
`else
   localparam int BRAUN_LATENCY = 1;
`endif

endpackage

// File: rtl/braun_multiplier_full_adder.sv
// One-bit full adder cell used by the carry-save and ripple rows of the Braun array.
// Latency: combinational. Backpressure: none.
// Backpressure behaviour: not applicable; this is a pure logic cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/braun_multiplier.sv
// Unsigned NxN Braun array multiplier with registered 2N-bit product; optional mid-array register via BRAUN_MULT_PIPE_EN.
// Latency: 1 cycle (2 with BRAUN_MULT_PIPE_EN). Throughput one product per cycle.
// Backpressure behaviour: none; out_valid is a pure delay of in_valid and p updates every cycle.
import braun_pkg::*;

module braun_multiplier #(
   parameter int N = BRAUN_N_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             in_valid,
   output logic [2*N-1:0]   p,
   output logic             out_valid
);

   localparam int PW = braun_prod_w(N);
   localparam int H  = braun_cut_row(N);

   // s[i][j] / c[i][j]: sum and carry leaving row i at column i+j.
   logic [N-1:0] pp [N];
   logic [N-1:0] s  [N];
   logic [N-2:0] c  [N];

   logic [N-1:0] s_cut;
   logic [N-2:0] c_cut;
   logic [H-1:0] lo;
   logic [H-1:0] lo_cut;
   logic         vld_cut;

   logic [N-1:0] s_last;
   logic [N-2:0] c_last;
   logic [N-2:0] rs;
   logic [N-1:0] rc;
   logic [PW-1:0] prod;

   genvar gi, gj;

   for (gi = 0; gi < N; gi++) begin : g_pp_row
      for (gj = 0; gj < N; gj++) begin : g_pp_bit
         assign pp[gi][gj] = a[gj] & b[gi];
      end
   end

   assign s[0] = pp[0];
   assign c[0] = '0;

   always_comb begin
      lo = '0;
      for (int i = 0; i < H; i++) begin
         lo[i] = s[i][0];
      end
   end

`ifdef BRAUN_MULT_PIPE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_cut   <= '0;
         c_cut   <= '0;
         lo_cut  <= '0;
         vld_cut <= 1'b0;
      end else begin
         s_cut   <= s[H];
         c_cut   <= c[H];
         lo_cut  <= lo;
         vld_cut <= in_valid;
      end
   end
`else
   assign s_cut   = s[H];
   assign c_cut   = c[H];
   assign lo_cut  = lo;
   assign vld_cut = in_valid;
`endif

   for (gi = 1; gi < N; gi++) begin : g_row
      logic [N-1:0] pp_use;
      logic [N-1:0] s_prev;
      logic [N-2:0] c_prev;
      logic [N-1:0] s_row;
      logic [N-2:0] c_row;

      if (gi == H + 1) begin : g_after_cut
         assign s_prev = s_cut;
         assign c_prev = c_cut;
      end else begin : g_chain
         assign s_prev = s[gi-1];
         assign c_prev = c[gi-1];
      end

`ifdef BRAUN_MULT_PIPE_EN
      // Rows past the cut consume partial products captured alongside the cut state.
      if (gi > H) begin : g_pp_late
         logic [N-1:0] pp_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pp_q <= '0;
            else        pp_q <= pp[gi];
         end
         assign pp_use = pp_q;
      end else begin : g_pp_early
         assign pp_use = pp[gi];
      end
`else
      assign pp_use = pp[gi];
`endif

      assign s_row[N-1] = pp_use[N-1];
      for (gj = 0; gj < N - 1; gj++) begin : g_fa
         full_adder u_fa (
            .a    (pp_use[gj]),
            .b    (s_prev[gj+1]),
            .cin  (c_prev[gj]),
            .s    (s_row[gj]),
            .cout (c_row[gj])
         );
      end

      assign s[gi] = s_row;
      assign c[gi] = c_row;
   end

   if (H == N - 1) begin : g_last_cut
      assign s_last = s_cut;
      assign c_last = c_cut;
   end else begin : g_last_chain
      assign s_last = s[N-1];
      assign c_last = c[N-1];
   end

   assign rc[0] = 1'b0;
   for (gj = 0; gj < N - 1; gj++) begin : g_rca
      full_adder u_rca (
         .a    (s_last[gj+1]),
         .b    (c_last[gj]),
         .cin  (rc[gj]),
         .s    (rs[gj]),
         .cout (rc[gj+1])
      );
   end

   always_comb begin
      prod         = '0;
      prod[H-1:0]  = lo_cut;
      prod[H]      = s_cut[0];
      for (int i = H + 1; i < N; i++) begin
         prod[i] = s[i][0];
      end
      prod[PW-2:N] = rs;
      prod[PW-1]   = rc[N-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p         <= '0;
         out_valid <= 1'b0;
      end else begin
         p         <= prod;
         out_valid <= vld_cut;
      end
   end

endmodule

// File: tb/tb_braun_multiplier.sv
// Scoreboard bench for braun_multiplier: 8-bit and 4-bit instances against a plain-arithmetic model.
module tb_braun_multiplier;

`ifdef BRAUN_MULT_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      longint prod;
      int     due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        in_valid = 1'b0;
   logic [15:0] p;
   logic        out_valid;
   logic [7:0]  p4;
   logic        out_valid4;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   ov_cnt = 0;
   exp_t q8[$];
   exp_t q4[$];
   exp_t e8, e4;
   logic ev8, ev4;

   braun_multiplier #(.N(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .p         (p),
      .out_valid (out_valid)
   );

   braun_multiplier #(.N(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a[3:0]),
      .b         (b[3:0]),
      .in_valid  (in_valid),
      .p         (p4),
      .out_valid (out_valid4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Inputs are applied just after an edge and sampled by the next one.
   task automatic issue(input logic v, input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      @(posedge clk);
      #1;
      a        = x;
      b        = y;
      in_valid = v;
      if (v) begin
         e.due  = cyc + LAT;
         e.prod = longint'(x) * longint'(y);
         q8.push_back(e);
         e.prod = longint'(x[3:0]) * longint'(y[3:0]);
         q4.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         ev8 = (q8.size() > 0) && (q8[0].due == cyc);
         check("out_valid_n8", longint'(out_valid), longint'(ev8));
         if (ev8) begin
            e8 = q8.pop_front();
            if (out_valid) check("product_n8", longint'(p), e8.prod);
         end
         if (out_valid) ov_cnt++;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         ev4 = (q4.size() > 0) && (q4[0].due == cyc);
         check("out_valid_n4", longint'(out_valid4), longint'(ev4));
         if (ev4) begin
            e4 = q4.pop_front();
            if (out_valid4) check("product_n4", longint'(p4), e4.prod);
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] da [11];
      logic [7:0] db [11];
      da = '{8'd0, 8'd10, 8'd12, 8'd17, 8'd111, 8'd156, 8'd255, 8'd255, 8'd1,   8'd128, 8'd0};
      db = '{8'd0, 8'd25, 8'd29, 8'd30, 8'd198, 8'd0,   8'd255, 8'd1,   8'd255, 8'd2,   8'd255};

      // Reset held with live operands and in_valid high.
      a        = 8'd200;
      b        = 8'd200;
      in_valid = 1'b1;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_p", longint'(p), 0);
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_p_n4", longint'(p4), 0);
      check("reset_out_valid_n4", longint'(out_valid4), 0);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      for (int i = 0; i < 11; i++) issue(1'b1, da[i], db[i]);

      for (int i = 0; i < 400; i++)
         issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

      // Exactly twenty back-to-back results after an idle gap.
      repeat (5) issue(1'b0, 8'($urandom), 8'($urandom));
      ov_cnt = 0;
      for (int i = 0; i < 20; i++) issue(1'b1, 8'($urandom), 8'($urandom));
      repeat (5) issue(1'b0, 8'($urandom), 8'($urandom));
      check("stream_out_valid_count", longint'(ov_cnt), 20);

      // Asynchronous reset between edges while results are in flight.
      for (int i = 0; i < 4; i++) issue(1'b1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
      @(posedge clk);
      #3;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midreset_p", longint'(p), 0);
      check("midreset_out_valid", longint'(out_valid), 0);
      check("midreset_out_valid_n4", longint'(out_valid4), 0);
      q8.delete();
      q4.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) issue(1'b0, 8'($urandom), 8'($urandom));

      for (int x = 0; x < 256; x++)
         for (int y = 0; y < 256; y++)
            issue(1'b1, 8'(x), 8'(y));

      repeat (LAT + 3) issue(1'b0, 8'd0, 8'd0);
      check("drain_n8", longint'(q8.size()), 0);
      check("drain_n4", longint'(q4.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
